// File: rtl/rd_act_sequencer.sv
// Burst read sequencer: issues len read strobes and delays each issued beat
// through a DELAY-stage stall-aware pipeline to form the activate strobe.
module rd_act_sequencer #(
    parameter int DELAY = 2,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             start,
    input  logic [LEN_W-1:0] len,
    input  logic             done,
    output logic             rd,
    output logic             act,
    output logic             busy,
    output logic             finish,
    output logic [LEN_W-1:0] rd_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t           state, state_next;
    logic [DELAY-1:0] sr, sr_shift, sr_next;
    logic [LEN_W-1:0] len_q, len_next;
    logic [LEN_W-1:0] cnt_next, cnt_inc;
    logic             rd_next, finish_next, issue;

    assign issue   = rd & en;
    assign cnt_inc = rd_cnt + LEN_W'(1);
    assign act     = sr[DELAY-1];

    // NOTE: every signal driven here gets a default before the case so no
    // path leaves it unassigned, which would otherwise infer a latch.
    always_comb begin
        sr_shift    = '0;
        sr_shift[0] = issue;
        for (int i = 1; i < DELAY; i++) begin
            sr_shift[i] = sr[i-1];
        end
        sr_next     = en ? sr_shift : sr;

        state_next  = state;
        rd_next     = rd;
        finish_next = 1'b0;
        cnt_next    = rd_cnt;
        len_next    = len_q;

        case (state)
            IDLE: begin
                if (start) begin
                    cnt_next = '0;
                    if (len != '0) begin
                        len_next   = len;
                        rd_next    = 1'b1;
                        state_next = RUN;
                    end else begin
                        finish_next = 1'b1;
                    end
                end
            end
            RUN: begin
                if (issue) begin
                    cnt_next = cnt_inc;
                end
                // An issue coinciding with done still counts; only further issues stop.
                if ((issue && cnt_inc == len_q) || done) begin
                    rd_next    = 1'b0;
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                // Complete once the pipeline will be empty after this edge, so
                // finish lands in the cycle right after the last act.
                if (sr_next == '0) begin
                    finish_next = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sr     <= '0;
            len_q  <= '0;
            rd     <= 1'b0;
            finish <= 1'b0;
            busy   <= 1'b0;
            rd_cnt <= '0;
        end else begin
            state  <= state_next;
            sr     <= sr_next;
            len_q  <= len_next;
            rd     <= rd_next;
            finish <= finish_next;
            busy   <= (state_next != IDLE);
            rd_cnt <= cnt_next;
        end
    end

endmodule

// File: tb/tb_rd_act_sequencer.sv
// Bench for rd_act_sequencer: three builds (DELAY 2, 1, 5) share stimulus and
// are compared each cycle against a beat-history model, plus directed checks.
module tb_rd_act_sequencer;

    localparam int N = 3;
    localparam int HIST = 4096;
    int dly [N] = '{2, 1, 5};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b0, start = 1'b0, done = 1'b0;
    logic [15:0] len = '0;

    logic [N-1:0] rd_v, act_v, busy_v, fin_v;
    logic [15:0]  cnt_v [N];

    int total = 0;
    int bad = 0;
    int cyc = 0;

    // Model: beats are tagged with the count of en-high cycles seen before
    // their issue; a beat tagged n shows as act while that count equals n+DELAY.
    int m_state [N];  // 0 idle, 1 run, 2 drain
    bit m_rd [N];
    bit m_fin [N];
    int m_cnt [N];
    int m_len [N];
    int m_e [N];
    bit m_hist [N][HIST];

    bit obs_rd [N], obs_act [N], obs_busy [N], obs_fin [N];
    int obs_cnt [N];
    bit obs_en;

    always #5 clk = ~clk;

    rd_act_sequencer #(.DELAY(2), .LEN_W(16)) u_d2 (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .len(len), .done(done),
        .rd(rd_v[0]), .act(act_v[0]), .busy(busy_v[0]), .finish(fin_v[0]), .rd_cnt(cnt_v[0]));
    rd_act_sequencer #(.DELAY(1), .LEN_W(16)) u_d1 (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .len(len), .done(done),
        .rd(rd_v[1]), .act(act_v[1]), .busy(busy_v[1]), .finish(fin_v[1]), .rd_cnt(cnt_v[1]));
    rd_act_sequencer #(.DELAY(5), .LEN_W(16)) u_d5 (
        .clk(clk), .rst_n(rst_n), .en(en), .start(start), .len(len), .done(done),
        .rd(rd_v[2]), .act(act_v[2]), .busy(busy_v[2]), .finish(fin_v[2]), .rd_cnt(cnt_v[2]));

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            m_state[i] = 0; m_rd[i] = 0; m_fin[i] = 0;
            m_cnt[i] = 0; m_len[i] = 0; m_e[i] = 0;
            for (int n = 0; n < HIST; n++) m_hist[i][n] = 0;
        end
    endtask

    function automatic bit model_act(input int i);
        int n = m_e[i] - dly[i];
        return (n >= 0) && m_hist[i][n];
    endfunction

    task automatic model_step(input int i, input bit e, input bit s, input int l, input bit d);
        bit iss = m_rd[i] && e;
        int ne = m_e[i] + (e ? 1 : 0);
        bit pending = 0;
        if (iss) m_hist[i][m_e[i]] = 1;
        m_fin[i] = 0;
        case (m_state[i])
            0: if (s) begin
                m_cnt[i] = 0;
                if (l != 0) begin
                    m_len[i] = l; m_rd[i] = 1; m_state[i] = 1;
                end else m_fin[i] = 1;
            end
            1: begin
                if (iss) m_cnt[i]++;
                if ((iss && m_cnt[i] == m_len[i]) || d) begin
                    m_rd[i] = 0; m_state[i] = 2;
                end
            end
            default: begin
                for (int n = ne - dly[i]; n < ne; n++)
                    if (n >= 0 && m_hist[i][n]) pending = 1;
                if (!pending) begin
                    m_fin[i] = 1; m_state[i] = 0;
                end
            end
        endcase
        m_e[i] = ne;
    endtask

    // One clock: drive inputs, compare all outputs mid-cycle, advance the model.
    task automatic cycle(input bit e, input bit s, input int l, input bit d);
        bit exp_act;
        en = e; start = s; len = l[15:0]; done = d;
        @(negedge clk);
        obs_en = e;
        for (int i = 0; i < N; i++) begin
            exp_act = model_act(i);
            obs_rd[i] = rd_v[i]; obs_act[i] = act_v[i]; obs_busy[i] = busy_v[i];
            obs_fin[i] = fin_v[i]; obs_cnt[i] = int'(cnt_v[i]);
            total += 5;
            if (rd_v[i] !== m_rd[i]) begin
                bad++; $display("FAIL rd d=%0d cyc=%0d got=%b exp=%b", dly[i], cyc, rd_v[i], m_rd[i]);
            end
            if (act_v[i] !== exp_act) begin
                bad++; $display("FAIL act d=%0d cyc=%0d got=%b exp=%b", dly[i], cyc, act_v[i], exp_act);
            end
            if (busy_v[i] !== (m_state[i] != 0)) begin
                bad++; $display("FAIL busy d=%0d cyc=%0d got=%b exp=%b", dly[i], cyc, busy_v[i], m_state[i] != 0);
            end
            if (fin_v[i] !== m_fin[i]) begin
                bad++; $display("FAIL finish d=%0d cyc=%0d got=%b exp=%b", dly[i], cyc, fin_v[i], m_fin[i]);
            end
            if (cnt_v[i] !== m_cnt[i][15:0]) begin
                bad++; $display("FAIL rd_cnt d=%0d cyc=%0d got=%0d exp=%0d", dly[i], cyc, cnt_v[i], m_cnt[i]);
            end
            model_step(i, e, s, l, d);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic flush();
        for (int k = 0; k < 20; k++) cycle(1, 0, 0, 1);
    endtask

    task automatic test_reset();
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int k = 0; k < 3; k++) cycle(1, 0, 0, 0);
    endtask

    task automatic test_basic_burst();
        int first_act [N], last_act [N], fin_c [N], rd_n [N], busy_n [N], cnt_f [N];
        for (int i = 0; i < N; i++) begin
            first_act[i] = -1; last_act[i] = -1; fin_c[i] = -1;
            rd_n[i] = 0; busy_n[i] = 0; cnt_f[i] = -1;
        end
        for (int c = 0; c < 14; c++) begin
            cycle(1, c == 0, 4, 0);
            for (int i = 0; i < N; i++) begin
                if (obs_act[i]) begin
                    if (first_act[i] < 0) first_act[i] = c;
                    last_act[i] = c;
                end
                if (obs_fin[i]) begin fin_c[i] = c; cnt_f[i] = obs_cnt[i]; end
                rd_n[i] += obs_rd[i];
                busy_n[i] += obs_busy[i];
            end
        end
        for (int i = 0; i < N; i++) begin
            total += 6;
            if (first_act[i] != 1 + dly[i]) begin bad++; $display("FAIL basic_first_act d=%0d got=%0d exp=%0d", dly[i], first_act[i], 1 + dly[i]); end
            if (last_act[i] != 4 + dly[i])  begin bad++; $display("FAIL basic_last_act d=%0d got=%0d exp=%0d", dly[i], last_act[i], 4 + dly[i]); end
            if (fin_c[i] != 5 + dly[i])     begin bad++; $display("FAIL basic_finish d=%0d got=%0d exp=%0d", dly[i], fin_c[i], 5 + dly[i]); end
            if (rd_n[i] != 4)               begin bad++; $display("FAIL basic_rd_cycles d=%0d got=%0d exp=4", dly[i], rd_n[i]); end
            if (busy_n[i] != 4 + dly[i])    begin bad++; $display("FAIL basic_busy_cycles d=%0d got=%0d exp=%0d", dly[i], busy_n[i], 4 + dly[i]); end
            if (cnt_f[i] != 4)              begin bad++; $display("FAIL basic_cnt_at_finish d=%0d got=%0d exp=4", dly[i], cnt_f[i]); end
        end
    endtask

    task automatic test_stall();
        int acts = 0, cnt_f = -1;
        for (int c = 0; c < 14; c++) begin
            cycle(!(c == 2 || c == 3), c == 0, 3, 0);
            if (c == 2 || c == 3) begin
                total += 2;
                if (obs_rd[0] !== 1'b1) begin bad++; $display("FAIL stall_rd cyc=%0d got=%b exp=1", c, obs_rd[0]); end
                if (obs_cnt[0] != 1)    begin bad++; $display("FAIL stall_cnt cyc=%0d got=%0d exp=1", c, obs_cnt[0]); end
            end
            if (obs_act[0] && obs_en) acts++;
            if (obs_fin[0]) cnt_f = obs_cnt[0];
        end
        total += 2;
        if (acts != 3)  begin bad++; $display("FAIL stall_act_beats got=%0d exp=3", acts); end
        if (cnt_f != 3) begin bad++; $display("FAIL stall_cnt_at_finish got=%0d exp=3", cnt_f); end
    endtask

    task automatic test_early_abort();
        int acts [N], fins [N];
        for (int i = 0; i < N; i++) begin acts[i] = 0; fins[i] = 0; end
        for (int c = 0; c < 16; c++) begin
            cycle(1, c == 0 || c == 4, (c == 0) ? 10 : 2, c == 3);
            if (c == 4) begin
                total += 2;
                if (obs_rd[0] !== 1'b0) begin bad++; $display("FAIL abort_rd got=%b exp=0", obs_rd[0]); end
                if (obs_cnt[0] != 3)    begin bad++; $display("FAIL abort_cnt got=%0d exp=3", obs_cnt[0]); end
            end
            for (int i = 0; i < N; i++) begin
                acts[i] += obs_act[i];
                fins[i] += obs_fin[i];
            end
        end
        for (int i = 0; i < N; i++) begin
            total += 2;
            if (acts[i] != 3) begin bad++; $display("FAIL abort_act_beats d=%0d got=%0d exp=3", dly[i], acts[i]); end
            if (fins[i] != 1) begin bad++; $display("FAIL abort_finish_count d=%0d got=%0d exp=1", dly[i], fins[i]); end
        end
    endtask

    task automatic test_zero_len();
        int rd_seen = 0, busy_seen = 0;
        for (int c = 0; c < 4; c++) begin
            cycle(1, c == 0, 0, 0);
            rd_seen += obs_rd[0] + obs_act[0];
            busy_seen += obs_busy[0];
            if (c == 1) begin
                total += 2;
                if (obs_fin[0] !== 1'b1) begin bad++; $display("FAIL zero_finish got=%b exp=1", obs_fin[0]); end
                if (obs_cnt[0] != 0)     begin bad++; $display("FAIL zero_cnt got=%0d exp=0", obs_cnt[0]); end
            end
        end
        total += 2;
        if (rd_seen != 0)   begin bad++; $display("FAIL zero_rd_act got=%0d exp=0", rd_seen); end
        if (busy_seen != 0) begin bad++; $display("FAIL zero_busy got=%0d exp=0", busy_seen); end
    endtask

    task automatic test_reset_mid_burst();
        for (int c = 0; c < 5; c++) cycle(1, c == 0, 6, 0);
        #2;
        rst_n = 1'b0;
        start = 1'b0;
        #1;
        for (int i = 0; i < N; i++) begin
            total++;
            if ({rd_v[i], act_v[i], busy_v[i], fin_v[i]} !== 4'b0 || cnt_v[i] !== 16'd0) begin
                bad++;
                $display("FAIL async_reset d=%0d got rd=%b act=%b busy=%b fin=%b cnt=%0d exp=all zero",
                         dly[i], rd_v[i], act_v[i], busy_v[i], fin_v[i], cnt_v[i]);
            end
        end
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int c = 0; c < 12; c++) cycle(1, c == 1, 2, 0);
    endtask

    task automatic test_delay_builds();
        int first_rd [N], first_act [N], fin_c [N];
        for (int i = 0; i < N; i++) begin first_rd[i] = -1; first_act[i] = -1; fin_c[i] = -1; end
        for (int c = 0; c < 12; c++) begin
            cycle(1, c == 0, 2, 0);
            for (int i = 0; i < N; i++) begin
                if (obs_rd[i] && first_rd[i] < 0) first_rd[i] = c;
                if (obs_act[i] && first_act[i] < 0) first_act[i] = c;
                if (obs_fin[i]) fin_c[i] = c;
            end
        end
        for (int i = 0; i < N; i++) begin
            total += 2;
            if (first_act[i] - first_rd[i] != dly[i]) begin
                bad++; $display("FAIL delay_trail d=%0d got=%0d exp=%0d", dly[i], first_act[i] - first_rd[i], dly[i]);
            end
            if (fin_c[i] != 3 + dly[i]) begin
                bad++; $display("FAIL delay_finish d=%0d got=%0d exp=%0d", dly[i], fin_c[i], 3 + dly[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 500; c++)
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 3) == 0,
                  int'($urandom_range(0, 6)), $urandom_range(0, 11) == 0);
    endtask

    initial begin
        test_reset();
        flush();
        test_basic_burst();
        flush();
        test_stall();
        flush();
        test_early_abort();
        flush();
        test_zero_len();
        flush();
        test_reset_mid_burst();
        flush();
        test_delay_builds();
        flush();
        test_random();
        flush();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
